spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_if.sv | 18 +
 rtl/spi_slave.sv | 98 +++++++++
 tb/tb_spi_slave.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus local register-file access port of spi_slave.
interface spi_slave_if;
   logic       sclk;
   logic       cs;
   logic       mosi;
   logic       miso;
   logic       enable;
   logic       read_write_;
   logic [2:0] madd;
   logic [7:0] data;
   logic [7:0] out;
   logic       rx_valid;
   logic       busy;
   modport slave (input sclk, cs, mosi, enable, read_write_, madd, data,
                  output miso, out, rx_valid, busy);
   modport master (output sclk, cs, mosi, enable, read_write_, madd, data,
                   input miso, out, rx_valid, busy);
endinterface

// File: rtl/spi_slave.sv
// spi_slave: mode-0 SPI slave over an 8x8 register file with a local read/write port.
module spi_slave (
   input logic        clk,
   input logic        rst,
   spi_slave_if.slave bus
);
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t     state_q, state_d;
   logic [2:0] sclk_q, cs_q;
   logic [1:0] mosi_q;
   logic [2:0] ptr_q, ptr_d, cnt_q, cnt_d;
   logic [7:0] rx_q, rx_d, tx_q, tx_d, out_q, out_d;
   logic       miso_q, miso_d, rxv_q, rxv_d;
   logic [7:0] mem_q [8];
   logic [7:0] mem_d [8];
   logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
   logic [7:0] rx_byte;
   logic [2:0] ptr_nx;
   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign rx_byte   = {rx_q[6:0], mosi_q[1]};
   assign ptr_nx    = ptr_q + 3'd1;
   assign bus.miso     = miso_q;
   assign bus.out      = out_q;
   assign bus.rx_valid = rxv_q;
   assign bus.busy     = state_q == SHIFT;
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      rx_d    = rx_q;
      tx_d    = tx_q;
      miso_d  = miso_q;
      rxv_d   = 1'b0;
      out_d   = out_q;
      mem_d   = mem_q;
      if (bus.enable && !bus.read_write_) mem_d[bus.madd] = bus.data;
      if (bus.enable && bus.read_write_) out_d = mem_q[bus.madd];
      // SPI byte write comes after the local write so it wins on an address clash
      if (state_q == IDLE) begin
         if (cs_fall) begin
            state_d = SHIFT;
            ptr_d   = 3'd0;
            cnt_d   = 3'd0;
            tx_d    = mem_q[0];
            miso_d  = mem_q[0][7];
         end
      end else if (cs_rise) begin
         state_d = IDLE;
         cnt_d   = 3'd0;
         miso_d  = 1'b0;
      end else if (sclk_rise) begin
         rx_d  = rx_byte;
         cnt_d = cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            mem_d[ptr_q] = rx_byte;
            rxv_d        = 1'b1;
            ptr_d        = ptr_nx;
            tx_d         = mem_q[ptr_nx];
            miso_d       = mem_q[ptr_nx][7];
         end
      end else if (sclk_fall && cnt_q != 3'd0) begin
         tx_d   = {tx_q[6:0], 1'b0};
         miso_d = tx_q[6];
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         sclk_q  <= 3'b000;
         cs_q    <= 3'b111;
         mosi_q  <= 2'b00;
         ptr_q   <= 3'd0;
         cnt_q   <= 3'd0;
         rx_q    <= 8'h00;
         tx_q    <= 8'h00;
         out_q   <= 8'h00;
         miso_q  <= 1'b0;
         rxv_q   <= 1'b0;
         for (int i = 0; i < 8; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q <= state_d;
         sclk_q  <= {sclk_q[1:0], bus.sclk};
         cs_q    <= {cs_q[1:0], bus.cs};
         mosi_q  <= {mosi_q[0], bus.mosi};
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         rx_q    <= rx_d;
         tx_q    <= tx_d;
         out_q   <= out_d;
         miso_q  <= miso_d;
         rxv_q   <= rxv_d;
         mem_q   <= mem_d;
      end
   end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed and randomized frames checked every cycle against a transaction-level model.
module tb_spi_slave;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   spi_slave_if bus();
   spi_slave dut (.clk(clk), .rst(rst), .bus(bus));
   int errs = 0, checks = 0, pulses = 0;
   logic [7:0] mm [8];
   logic [2:0] mptr = 3'd0;
   logic [7:0] cur = 8'h00;
   int         ebits = 0;
   logic       ebusy = 1'b0, erxv = 1'b0, emiso = 1'b0;
   logic [7:0] eout = 8'h00;
   logic [7:0] send [16];
   logic [7:0] cap [16];
   int         coll_byte = -1;
   logic [2:0] coll_addr = 3'd0;
   logic [7:0] coll_data = 8'h00;
   logic [7:0] w [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
   task automatic check(input string n, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s: got %02h expected %02h at %0t", n, a, e, $time);
      end
   endtask
   always @(negedge clk) begin
      check("busy", {7'd0, bus.busy}, {7'd0, ebusy});
      check("rx_valid", {7'd0, bus.rx_valid}, {7'd0, erxv});
      check("miso", {7'd0, bus.miso}, {7'd0, emiso});
      check("out", bus.out, eout);
      if (bus.rx_valid === 1'b1) pulses++;
   end
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic lwrite(input logic [2:0] a, input logic [7:0] d);
      bus.enable = 1'b1; bus.read_write_ = 1'b0; bus.madd = a; bus.data = d;
      tick(1);
      mm[a] = d;
      bus.enable = 1'b0;
   endtask
   task automatic lread(input logic [2:0] a, input logic [7:0] lit, input string n);
      bus.enable = 1'b1; bus.read_write_ = 1'b1; bus.madd = a;
      tick(1);
      eout = mm[a];
      bus.enable = 1'b0;
      check(n, bus.out, lit);
   endtask
   task automatic send_bit(input logic b, input int h, input int bi, input int j);
      bus.mosi = b;
      tick(h);
      cap[bi] = {cap[bi][6:0], bus.miso};
      bus.sclk = 1'b1;
      if (bi == coll_byte && j == 0) begin
         tick(2);
         bus.enable = 1'b1; bus.read_write_ = 1'b0; bus.madd = coll_addr; bus.data = coll_data;
         tick(1);
         bus.enable = 1'b0;
         mm[coll_addr] = coll_data;
      end else tick(3);
      ebits++;
      if (ebits == 8) begin
         mm[mptr] = send[bi];
         mptr++;
         cur = mm[mptr];
         emiso = cur[7];
         ebits = 0;
         erxv = 1'b1;
         tick(1);
         erxv = 1'b0;
         tick(h - 4);
      end else tick(h - 3);
      bus.sclk = 1'b0;
      tick(3);
      if (ebits != 0) emiso = cur[7 - ebits];
      tick(h - 3);
   endtask
   task automatic frame(input int nb, input int part, input int h);
      bus.cs = 1'b0;
      tick(3);
      ebusy = 1'b1; mptr = 3'd0; ebits = 0; cur = mm[0]; emiso = cur[7];
      tick(h);
      for (int i = 0; i < nb; i++) begin
         cap[i] = 8'h00;
         for (int j = 7; j >= 0; j--) send_bit(send[i][j], h, i, j);
      end
      for (int j = 7; j > 7 - part; j--) send_bit(send[nb][j], h, nb, j);
      bus.cs = 1'b1;
      tick(3);
      ebusy = 1'b0; emiso = 1'b0;
      tick(2);
   endtask
   initial begin
      int p0, nb, part;
      for (int i = 0; i < 8; i++) mm[i] = 8'h00;
      bus.sclk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
      bus.enable = 1'b0; bus.read_write_ = 1'b0; bus.madd = 3'd0; bus.data = 8'h00;
      tick(3);
      check("reset_out", bus.out, 8'h00);
      check("reset_busy", {7'd0, bus.busy}, 8'h00);
      rst = 1'b1;
      tick(2);
      for (int i = 0; i < 8; i++) lwrite(3'(i), w[i]);
      for (int i = 0; i < 8; i++) lread(3'(i), w[i], "local_rd");
      p0 = pulses;
      send[0] = 8'hA5;
      frame(1, 0, 4);
      check("one_byte_miso", cap[0], 8'h12);
      check("one_byte_pulses", 8'(pulses - p0), 8'd1);
      check("busy_after_cs", {7'd0, bus.busy}, 8'h00);
      lread(3'd0, 8'hA5, "one_byte_mem0");
      lwrite(3'd0, 8'h12);
      for (int i = 0; i < 9; i++) send[i] = 8'(i);
      p0 = pulses;
      frame(9, 0, 5);
      for (int i = 0; i < 8; i++) check("nine_byte_miso", cap[i], w[i]);
      check("nine_byte_wrap_miso", cap[8], 8'h00);
      check("nine_byte_pulses", 8'(pulses - p0), 8'd9);
      lread(3'd0, 8'h08, "nine_byte_mem0");
      lread(3'd7, 8'h07, "nine_byte_mem7");
      p0 = pulses;
      send[0] = 8'hFF;
      frame(0, 5, 4);
      check("partial_pulses", 8'(pulses - p0), 8'd0);
      check("partial_miso", {7'd0, bus.miso}, 8'h00);
      for (int i = 0; i < 8; i++) lread(3'(i), mm[i], "partial_mem");
      lread(3'd2, 8'h02, "partial_mem2");
      send[0] = 8'h11; send[1] = 8'h3C;
      coll_byte = 1; coll_addr = 3'd1; coll_data = 8'hFF;
      frame(2, 0, 4);
      lread(3'd1, 8'h3C, "coll_same_addr");
      send[0] = 8'hC3;
      coll_byte = 0; coll_addr = 3'd5; coll_data = 8'h77;
      frame(1, 0, 6);
      coll_byte = -1;
      lread(3'd5, 8'h77, "coll_diff_local");
      lread(3'd0, 8'hC3, "coll_diff_spi");
      for (int r = 0; r < 8; r++) begin
         for (int k = $urandom_range(0, 3); k > 0; k--) lwrite(3'($urandom_range(0, 7)), 8'($urandom));
         nb = $urandom_range(1, 10);
         part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         for (int i = 0; i < 11; i++) send[i] = 8'($urandom);
         p0 = pulses;
         frame(nb, part, $urandom_range(4, 7));
         check("rand_pulses", 8'(pulses - p0), 8'(nb));
         for (int i = 0; i < 8; i++) lread(3'(i), mm[i], "rand_mem");
      end
      send[0] = 8'hE7;
      bus.cs = 1'b0;
      tick(3);
      ebusy = 1'b1; mptr = 3'd0; ebits = 0; cur = mm[0]; emiso = cur[7];
      tick(4);
      for (int j = 7; j > 4; j--) send_bit(send[0][j], 4, 0, j);
      rst = 1'b0; bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
      for (int i = 0; i < 8; i++) mm[i] = 8'h00;
      ebusy = 1'b0; emiso = 1'b0; erxv = 1'b0; eout = 8'h00; ebits = 0;
      #1;
      check("rst_miso", {7'd0, bus.miso}, 8'h00);
      check("rst_busy", {7'd0, bus.busy}, 8'h00);
      check("rst_out", bus.out, 8'h00);
      tick(3);
      rst = 1'b1;
      tick(3);
      for (int i = 0; i < 8; i++) lread(3'(i), 8'h00, "rst_mem");
      send[0] = 8'h5A;
      p0 = pulses;
      frame(1, 0, 4);
      check("post_rst_miso", cap[0], 8'h00);
      check("post_rst_pulses", 8'(pulses - p0), 8'd1);
      lread(3'd0, 8'h5A, "post_rst_mem0");
      lread(3'd1, 8'h00, "post_rst_mem1");
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
